controlador_display: RTL

//  Time-multiplexed scan controller that shares one 5-bit character decoder among
//  N_DIG seven-segment digits. Holds a message buffer of 5-bit character codes and

---
 rtl/controlador_display.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/controlador_display.sv
// ---------------------------------------------------------------------------
// controlador_display
//
// Time-multiplexed scan controller that shares one 5-bit character decoder
// among N_DIG seven-segment digits. A message buffer of 5-bit character codes
// is written while idle, then shown either fixed (static) or scrolling left.
//
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous reset, active low
//   wr_en    buffer write strobe, honoured only while idle
//   wr_addr  buffer write address
//   wr_data  character code to store
//   len      message length, sampled when a start is accepted
//   modo     0 = static, 1 = scroll; sampled when a start is accepted
//   start    begin display (one-cycle pulse)
//   stop     end display, return to idle
//   codigo   character code to the decoder, registered
//   anodo    digit enables, active low, at most one low; bit 0 = leftmost
//   busy     high while a message is being displayed
// ---------------------------------------------------------------------------
module controlador_display #(
    parameter int N_DIG        = 4,
    parameter int PRESC        = 50000,
    parameter int SCROLL_TICKS = 250,
    parameter int MSG_LEN      = 16,
    localparam int AW = $clog2(MSG_LEN),
    localparam int LW = AW + 1,
    localparam int DW = (N_DIG > 1) ? $clog2(N_DIG) : 1,
    localparam int PW = $clog2(PRESC),
    localparam int FW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [4:0]       wr_data,
    input  logic [LW-1:0]    len,
    input  logic             modo,
    input  logic             start,
    input  logic             stop,
    output logic [4:0]       codigo,
    output logic [N_DIG-1:0] anodo,
    output logic             busy
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ESTATICO = 2'd1,
        ROLAGEM  = 2'd2
    } estado_t;

    estado_t          estado;
    logic [PW-1:0]    presc_cnt;
    logic [DW-1:0]    dig;
    logic [AW-1:0]    offset;
    logic [FW-1:0]    frame_cnt;
    logic [LW-1:0]    len_l;
    logic             primeiro;

    logic [4:0]       msg_buf [MSG_LEN];

    logic             tick;
    logic             fim_quadro;
    logic             avanca;
    logic [DW-1:0]    dig_n;
    logic [AW-1:0]    offset_n;
    logic [LW:0]      soma;
    logic [LW:0]      resto;
    logic [AW-1:0]    idx;
    logic             resto_unused;
    logic [4:0]       codigo_n;
    logic [N_DIG-1:0] anodo_n;
    logic [LW-1:0]    len_clamp;

    assign busy = (estado != OCIOSO);

    // The message buffer has no reset: its contents survive a reset and a
    // stop. Writes are only taken while idle, so a running display never
    // sees its characters change underneath it. A write coinciding with an
    // accepted start lands on the same edge, so the first load already
    // reads the new character.
    always_ff @(posedge clk) begin
        if (wr_en && (estado == OCIOSO)) begin
            msg_buf[wr_addr] <= wr_data;
        end
    end

    // Next-state arithmetic for the scan. The output register is loaded with
    // the digit, offset and character that will be current after this edge,
    // so the display always matches the scan position one clock after a tick.
    // A scroll step decided on a frame-ending tick therefore already affects
    // the leftmost digit of the following frame. The modulo by the latched
    // length handles any length from 1 to MSG_LEN, including lengths shorter
    // than the number of digits.
    always_comb begin
        tick       = (presc_cnt == PW'(PRESC - 1));
        fim_quadro = tick && (dig == DW'(N_DIG - 1));
        avanca     = (estado == ROLAGEM) && fim_quadro &&
                     (frame_cnt == FW'(SCROLL_TICKS - 1));

        dig_n = dig;
        if (tick) begin
            dig_n = (dig == DW'(N_DIG - 1)) ? '0 : dig + DW'(1);
        end

        offset_n = offset;
        if (avanca) begin
            offset_n = ((LW'(offset) + LW'(1)) == len_l) ? '0 : offset + AW'(1);
        end

        soma  = (LW + 1)'(offset_n) + (LW + 1)'(dig_n);
        resto = '0;
        if (len_l != '0) begin
            resto = soma % (LW + 1)'(len_l);
        end
        idx          = resto[AW-1:0];
        resto_unused = ^resto[LW:AW];

        anodo_n  = ~(N_DIG'(1) << dig_n);
        codigo_n = msg_buf[idx];
        if (estado == ESTATICO) begin
            if (LW'(dig_n) < len_l) begin
                codigo_n = msg_buf[AW'(dig_n)];
            end else begin
                anodo_n  = '1;
                codigo_n = '0;
            end
        end

        len_clamp = (len > LW'(MSG_LEN)) ? LW'(MSG_LEN) : len;
    end

    // Control FSM with registered outputs. While idle every scan counter is
    // held at zero and the digits are blanked. An accepted start latches the
    // mode and clamped length and flags the first busy cycle so the first
    // digit is shown without waiting a full dwell period. Stop has priority
    // over start and returns to idle, blanking the display on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= OCIOSO;
            presc_cnt <= '0;
            dig       <= '0;
            offset    <= '0;
            frame_cnt <= '0;
            len_l     <= '0;
            primeiro  <= 1'b0;
            codigo    <= '0;
            anodo     <= '1;
        end else begin
            case (estado)
                OCIOSO: begin
                    presc_cnt <= '0;
                    dig       <= '0;
                    offset    <= '0;
                    frame_cnt <= '0;
                    primeiro  <= 1'b0;
                    codigo    <= '0;
                    anodo     <= '1;
                    if (start && !stop && (len != '0)) begin
                        estado   <= modo ? ROLAGEM : ESTATICO;
                        len_l    <= len_clamp;
                        primeiro <= 1'b1;
                    end
                end
                default: begin
                    if (stop) begin
                        estado    <= OCIOSO;
                        presc_cnt <= '0;
                        dig       <= '0;
                        offset    <= '0;
                        frame_cnt <= '0;
                        primeiro  <= 1'b0;
                        codigo    <= '0;
                        anodo     <= '1;
                    end else begin
                        presc_cnt <= tick ? '0 : presc_cnt + PW'(1);
                        dig       <= dig_n;
                        offset    <= offset_n;
                        primeiro  <= 1'b0;
                        if ((estado == ROLAGEM) && fim_quadro) begin
                            frame_cnt <= (frame_cnt == FW'(SCROLL_TICKS - 1)) ?
                                         '0 : frame_cnt + FW'(1);
                        end
                        if (primeiro || tick) begin
                            codigo <= codigo_n;
                            anodo  <= anodo_n;
                        end
                    end
                end
            endcase
        end
    end

endmodule
